// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 core.
package msrv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;

endpackage

// File: rtl/msrv32_integer_file.sv
// Integer register file: x1..x31 stored, x0 hardwired to zero, two async reads.
// Define MSRV32_RF_BYPASS_EN to forward same-cycle write data to the read ports.
import msrv32_pkg::*;

module msrv32_integer_file #(
    parameter int XLEN  = msrv32_pkg::XLEN,
    parameter int NREGS = msrv32_pkg::NREGS
) (
    input  logic                  ms_riscv32_mp_clk_in,
    input  logic                  ms_riscv32_mp_rst_in,
    input  logic [REG_ADDR_W-1:0] rs_1_addr_in,
    input  logic [REG_ADDR_W-1:0] rs_2_addr_in,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic                  wr_en_in,
    input  logic [XLEN-1:0]       rd_in,
    output logic [XLEN-1:0]       rs_1_out,
    output logic [XLEN-1:0]       rs_2_out
);

    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];
    logic            wr_live;

    assign wr_live = wr_en_in && (rd_addr_in != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[rd_addr_in] = rd_in;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs_1_out = '0;
        if (rs_1_addr_in != '0) begin
            rs_1_out = regs_q[rs_1_addr_in];
        end
`ifdef MSRV32_RF_BYPASS_EN
        if (!ms_riscv32_mp_rst_in && wr_live && (rs_1_addr_in == rd_addr_in)) begin
            rs_1_out = rd_in;
        end
`endif
    end

    always_comb begin
        rs_2_out = '0;
        if (rs_2_addr_in != '0) begin
            rs_2_out = regs_q[rs_2_addr_in];
        end
`ifdef MSRV32_RF_BYPASS_EN
        if (!ms_riscv32_mp_rst_in && wr_live && (rs_2_addr_in == rd_addr_in)) begin
            rs_2_out = rd_in;
        end
`endif
    end

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Directed self-checking bench for msrv32_integer_file.
module tb_msrv32_integer_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_a;
    logic [4:0]  rs2_a;
    logic [4:0]  rd_a;
    logic        wr_en;
    logic [31:0] rd_d;
    logic [31:0] rs1_o;
    logic [31:0] rs2_o;

    int tests;
    int fails;

    msrv32_integer_file dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .rs_1_addr_in         (rs1_a),
        .rs_2_addr_in         (rs2_a),
        .rd_addr_in           (rd_a),
        .wr_en_in             (wr_en),
        .rd_in                (rd_d),
        .rs_1_out             (rs1_o),
        .rs_2_out             (rs2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rd_a  = a;
        rd_d  = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1_a = 5'(a);
            rs2_a = 5'(31 - a);
            #1;
            tests++;
            if (rs1_o !== 32'h0 || rs2_o !== 32'h0) begin
                fails++;
                $display("FAIL reset_clear a=%0d rs1=%h rs2=%h want 0", a, rs1_o, rs2_o);
            end
        end
        wr(5'd5, 32'hDEADBEEF);
        rs1_a = 5'd5;
        #1;
        tests++;
        if (rs1_o !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL x5_written got %h want deadbeef", rs1_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if (rs1_o !== 32'h0) begin
            fails++;
            $display("FAIL x5_after_reset got %h want 0", rs1_o);
        end
    endtask

    task automatic test_x0;
        @(negedge clk);
        rd_a  = 5'd0;
        rd_d  = 32'hFFFFFFFF;
        wr_en = 1'b1;
        rs1_a = 5'd0;
        rs2_a = 5'd0;
        #1;
        tests++;
        if (rs1_o !== 32'h0 || rs2_o !== 32'h0) begin
            fails++;
            $display("FAIL x0_during rs1=%h rs2=%h want 0", rs1_o, rs2_o);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        tests++;
        if (rs1_o !== 32'h0) begin
            fails++;
            $display("FAIL x0_after got %h want 0", rs1_o);
        end
    endtask

    task automatic test_dual_read;
        wr(5'd3, 32'h11111111);
        wr(5'd4, 32'h22222222);
        rs1_a = 5'd3;
        rs2_a = 5'd4;
        #1;
        tests++;
        if (rs1_o !== 32'h11111111 || rs2_o !== 32'h22222222) begin
            fails++;
            $display("FAIL dual_read rs1=%h rs2=%h want 11111111 22222222", rs1_o, rs2_o);
        end
        rs1_a = 5'd4;
        rs2_a = 5'd4;
        #1;
        tests++;
        if (rs1_o !== 32'h22222222 || rs2_o !== 32'h22222222) begin
            fails++;
            $display("FAIL same_reg rs1=%h rs2=%h want 22222222", rs1_o, rs2_o);
        end
    endtask

    task automatic test_disabled_write;
        wr(5'd7, 32'h5);
        @(negedge clk);
        rd_a  = 5'd7;
        rd_d  = 32'hAAAA;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        rs1_a = 5'd7;
        #1;
        tests++;
        if (rs1_o !== 32'h5) begin
            fails++;
            $display("FAIL disabled_write got %h want 5", rs1_o);
        end
    endtask

    task automatic test_bypass;
        logic [31:0] exp_now;
`ifdef MSRV32_RF_BYPASS_EN
        exp_now = 32'h1234;
`else
        exp_now = 32'h1;
`endif
        wr(5'd9, 32'h1);
        @(negedge clk);
        rd_a  = 5'd9;
        rd_d  = 32'h1234;
        wr_en = 1'b1;
        rs1_a = 5'd9;
        rs2_a = 5'd9;
        #1;
        tests++;
        if (rs1_o !== exp_now || rs2_o !== exp_now) begin
            fails++;
            $display("FAIL bypass_same_cycle rs1=%h rs2=%h want %h", rs1_o, rs2_o, exp_now);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        tests++;
        if (rs1_o !== 32'h1234 || rs2_o !== 32'h1234) begin
            fails++;
            $display("FAIL bypass_next rs1=%h rs2=%h want 1234", rs1_o, rs2_o);
        end
    endtask

    task automatic test_reset_vs_write;
        wr(5'd10, 32'h55);
        @(negedge clk);
        rst   = 1'b1;
        rd_a  = 5'd10;
        rd_d  = 32'h77;
        wr_en = 1'b1;
        rs1_a = 5'd10;
        rs2_a = 5'd3;
        #1;
        tests++;
        if (rs1_o !== 32'h55) begin
            fails++;
            $display("FAIL no_bypass_in_reset got %h want 55", rs1_o);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        #1;
        tests++;
        if (rs1_o !== 32'h0 || rs2_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_vs_write rs1=%h rs2=%h want 0", rs1_o, rs2_o);
        end
    endtask

    task automatic test_back_to_back;
        wr(5'd31, 32'hCAFEF00D);
        wr(5'd1, 32'h0BADF00D);
        rs1_a = 5'd31;
        rs2_a = 5'd1;
        #1;
        tests++;
        if (rs1_o !== 32'hCAFEF00D || rs2_o !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL back_to_back rs1=%h rs2=%h want cafef00d 0badf00d", rs1_o, rs2_o);
        end
        wr(5'd31, 32'h12345678);
        #1;
        tests++;
        if (rs1_o !== 32'h12345678 || rs2_o !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL overwrite rs1=%h rs2=%h want 12345678 0badf00d", rs1_o, rs2_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        rs1_a = '0;
        rs2_a = '0;
        rd_a  = '0;
        wr_en = 1'b0;
        rd_d  = '0;
        test_reset();
        test_x0();
        test_dual_read();
        test_disabled_write();
        test_bypass();
        test_reset_vs_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
